// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds a serializer.
// Back-to-back frames leave no idle gap while the FIFO still holds bytes.
module uart_tx_fifo #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int Depth     = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [7:0]                   DataIn,
    input  logic                         DataInValid,
    output logic                         DataInReady,
    output logic                         SOut,
    output logic                         Busy,
    output logic [$clog2(Depth+1)-1:0]   Level
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int CntW   = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam int PtrW   = $clog2(Depth);
    localparam int LevelW = $clog2(Depth + 1);
    localparam logic [CntW-1:0]   CntLast   = CntW'(SymbolEdgeTime - 1);
    localparam logic [LevelW-1:0] LevelFull = LevelW'(Depth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [CntW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]      bit_idx, bit_idx_next;
    logic [7:0]      shift, shift_next;
    logic            sout_next;
    logic [7:0]      mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic            push, pop, symbol_end;

    // Ready looks only at registered occupancy, so a same-cycle pop never opens it early.
    assign DataInReady = (Level != LevelFull);
    assign push        = DataInValid && DataInReady;
    assign symbol_end  = (baud_cnt == CntLast);
    assign Busy        = (state != IDLE) || (Level != '0);

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            SOut     <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            SOut     <= sout_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        pop           = 1'b0;
        sout_next     = 1'b1;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (Level != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (symbol_end) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (symbol_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end
            end
            STOP: begin
                if (symbol_end) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (Level != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            START:   sout_next = 1'b0;
            DATA:    sout_next = shift_next[0];
            default: sout_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table-driven single frames plus sequences for
// back-pressure, reset mid-frame, simultaneous push/pop and a default-rate decode.
module tb_uart_tx_fifo;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] data_in, data2;
    logic       data_valid, valid2;
    logic       ready, sout, busy;
    logic       ready2, sout2, busy2;
    logic [2:0] level, level2;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    uart_tx_fifo #(.ClockFreq(1000), .BaudRate(100), .Depth(4)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(data_in), .DataInValid(data_valid),
        .DataInReady(ready), .SOut(sout), .Busy(busy), .Level(level)
    );

    uart_tx_fifo dut_def (
        .Clock(Clock), .Reset(Reset), .DataIn(data2), .DataInValid(valid2),
        .DataInReady(ready2), .SOut(sout2), .Busy(busy2), .Level(level2)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } frame_vec_t;

    frame_vec_t vectors [4];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // First sample is the current cycle, i.e. right after the edge that entered START.
    task automatic check_frame(input logic [9:0] line, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i != 0) tick();
            if (sout !== line[i / 10]) bad++;
        end
        check_output(name, bad, 0);
    endtask

    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int waited;
        waited = 0;
        b  = '0;
        ok = 1'b1;
        while (sout2 !== 1'b0 && waited < 20000) begin
            tick();
            waited++;
        end
        if (waited >= 20000) begin
            ok = 1'b0;
            return;
        end
        repeat (217) tick();
        if (sout2 !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (434) tick();
            b[i] = sout2;
        end
        repeat (434) tick();
        if (sout2 !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] t3_bytes [6];
        int         accept_edge [6];
        int         frame_bad [6];
        int         ptr, bad, idx, f, s;
        logic       acc, ok;
        logic [9:0] fl;
        logic [7:0] got;
        logic [7:0] rx_exp [3];

        vectors[0] = '{8'hAA, 10'b1101010100};
        vectors[1] = '{8'h0F, 10'b1000011110};
        vectors[2] = '{8'h81, 10'b1100000010};
        vectors[3] = '{8'h3C, 10'b1001111000};
        t3_bytes   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        rx_exp     = '{8'h5A, 8'hFF, 8'h00};

        Reset = 1'b0; data_in = '0; data_valid = 1'b0; data2 = '0; valid2 = 1'b0;

        // T1: reset values, then an undisturbed idle line
        repeat (2) @(posedge Clock);
        #1;
        check_output("t1_sout", sout, 1);
        check_output("t1_ready", ready, 1);
        check_output("t1_busy", busy, 0);
        check_output("t1_level", level, 0);
        check_output("t1_def_sout", sout2, 1);
        @(negedge Clock) Reset = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if (sout !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_output("t1_idle_cycles_bad", bad, 0);

        // T2: table of single frames
        foreach (vectors[v]) begin
            apply_stimulus(vectors[v].data);
            check_output($sformatf("t2_%0h_level_after_push", vectors[v].data), level, 1);
            check_output($sformatf("t2_%0h_sout_still_idle", vectors[v].data), sout, 1);
            tick();
            check_frame(vectors[v].line, $sformatf("t2_%0h_frame_bad_cycles", vectors[v].data));
            check_output($sformatf("t2_%0h_busy_in_stop", vectors[v].data), busy, 1);
            tick();
            check_output($sformatf("t2_%0h_busy_after", vectors[v].data), busy, 0);
            check_output($sformatf("t2_%0h_sout_after", vectors[v].data), sout, 1);
        end

        // T3: stalled producer fills the FIFO; six contiguous frames
        ptr = 0;
        foreach (accept_edge[i]) accept_edge[i] = -1;
        foreach (frame_bad[i]) frame_bad[i] = 0;
        for (int e = 0; e <= 601; e++) begin
            data_in    = (ptr < 6) ? t3_bytes[ptr] : 8'h00;
            data_valid = (ptr < 6);
            acc        = data_valid && ready;
            tick();
            if (acc) begin
                accept_edge[ptr] = e;
                ptr++;
            end
            if (e == 4) begin
                check_output("t3_level_full", level, 4);
                check_output("t3_ready_full", ready, 0);
            end
            if (e >= 1 && e <= 600) begin
                idx = e - 1;
                f   = idx / 100;
                s   = (idx % 100) / 10;
                fl  = {1'b1, t3_bytes[f], 1'b0};
                if (sout !== fl[s]) frame_bad[f]++;
            end
        end
        data_valid = 1'b0;
        check_output("t3_busy_end", busy, 0);
        check_output("t3_sout_end", sout, 1);
        for (int i = 0; i < 5; i++) check_output($sformatf("t3_accept_edge_%0d", i), accept_edge[i], i);
        check_output("t3_accept_edge_5", accept_edge[5], 102);
        for (int i = 0; i < 6; i++) check_output($sformatf("t3_frame%0d_bad_cycles", i), frame_bad[i], 0);

        // T6: push lands on the STOP->START pop edge
        apply_stimulus(8'h55);
        apply_stimulus(8'hC3);
        check_output("t6_level_start", level, 1);
        fl = {1'b1, 8'h55, 1'b0};
        check_frame(fl, "t6_frame55_bad_cycles");
        check_output("t6_level_stop_last", level, 1);
        data_in = 8'h33; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check_output("t6_level_after_pushpop", level, 1);
        fl = {1'b1, 8'hC3, 1'b0};
        check_frame(fl, "t6_frameC3_bad_cycles");
        tick();
        fl = {1'b1, 8'h33, 1'b0};
        check_frame(fl, "t6_frame33_bad_cycles");
        tick();
        check_output("t6_busy_end", busy, 0);

        // T4: reset during data bit 3 with a byte still queued
        apply_stimulus(8'h0F);
        apply_stimulus(8'h00);
        repeat (42) tick();
        check_output("t4_level_before", level, 1);
        check_output("t4_busy_before", busy, 1);
        #2 Reset = 1'b0;
        #1;
        check_output("t4_sout_async", sout, 1);
        check_output("t4_level_async", level, 0);
        check_output("t4_busy_async", busy, 0);
        check_output("t4_ready_async", ready, 1);
        @(negedge Clock) Reset = 1'b1;
        bad = 0;
        repeat (300) begin
            tick();
            if (sout !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_output("t4_idle_after_bad", bad, 0);

        // T4b: reset while the line is low must raise it before any edge
        apply_stimulus(8'h0F);
        repeat (3) tick();
        check_output("t4b_sout_low", sout, 0);
        #2 Reset = 1'b0;
        #1;
        check_output("t4b_sout_async", sout, 1);
        @(negedge Clock) Reset = 1'b1;
        tick();

        // T5: default-rate instance decoded at mid-symbol
        data2 = 8'h5A; valid2 = 1'b1;
        tick();
        data2 = 8'hFF;
        tick();
        data2 = 8'h00;
        tick();
        valid2 = 1'b0;
        for (int r = 0; r < 3; r++) begin
            rx_byte(got, ok);
            check_output($sformatf("t5_rx%0d_framing", r), ok, 1);
            check_output($sformatf("t5_rx%0d_data", r), got, rx_exp[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter. It is the serializing end of the CPU serial link.
- Accepts bytes from the IO interface over a valid/ready handshake and queues them in a small FIFO.
- Emits 8N1 frames on the FPGA serial output pin.
- Replaces the single-byte transmit path, so software can write several bytes to the transmit address without polling between each one.

Parameters:
- ClockFreq, 50_000_000, system clock frequency in Hz.
- BaudRate, 115_200, serial bit rate.
- Depth, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- DataIn  input  8  byte to transmit.
- DataInValid  input  1  DataIn holds a valid byte.
- DataInReady  output  1  FIFO can accept a byte this cycle.
- SOut  output  1  serial line; idles high.
- Busy  output  1  a frame is in progress, or the FIFO is non-empty.
- Level  output  $clog2(Depth+1)  current FIFO occupancy.

Behaviour:
- Reset (Reset=0, asynchronous):
  - SOut=1, DataInReady=1, Busy=0, Level=0.
  - FIFO pointers cleared; state=IDLE; baud counter=0.
  - Any frame in progress is abandoned; SOut goes high without waiting for a clock edge.
- Symbol length: SymbolEdgeTime = ClockFreq/BaudRate clock cycles, integer division.
- Push (handshake):
  - A byte is pushed on a rising edge where DataInValid=1 and DataInReady=1.
  - DataInReady = (Level != Depth). It is driven from registered occupancy only and never depends on a pop in the same cycle.
- Pop: the FIFO pops only on a transition into START.
  - If a push and a pop occur on the same edge, Level is unchanged and the data stays in order.
- FIFO: circular buffer, FIFO order.
  - Pointers are $clog2(Depth) bits wide and wrap naturally.
  - A full/empty flag or an extra pointer bit distinguishes full from empty.
- State machine (SOut is registered):
  - IDLE: SOut=1.
    - If the FIFO is non-empty: pop the head into the shift register, go to START, clear the baud counter.
    - A byte pushed at edge k into an empty FIFO gives SOut=0 after edge k+1.
  - START: SOut=0 for SymbolEdgeTime cycles, then go to DATA with bit index 0.
  - DATA: SOut = shift[0], sent LSB first.
    - Each bit is held SymbolEdgeTime cycles, then the register shifts right.
    - After bit index 7 completes, go to STOP.
  - STOP: SOut=1 for SymbolEdgeTime cycles, then:
    - If the FIFO is non-empty: pop and go straight to START (no idle gap between frames).
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0 to SymbolEdgeTime-1.
  - A symbol ends when the counter equals SymbolEdgeTime-1; the counter then returns to 0.
- Busy = (state != IDLE) or (Level != 0).
- Stalled producer: DataInValid may stay high while DataInReady=0. The byte is accepted exactly once, on the first edge where ready is 1; no byte is dropped or duplicated.
- DataIn is sampled only on the accepting edge.

Test Plan:
- Use ClockFreq=1000, BaudRate=100 (10 cycles/bit) unless noted.
- T1, reset values: hold Reset=0 for 2 cycles -> SOut=1, DataInReady=1, Busy=0, Level=0. Release reset with no input -> SOut stays 1 for 50 cycles.
- T2, single frame: push 0xAA at edge k -> SOut=0 after edge k+1. Line sequence 0,0,1,0,1,0,1,0,1,1, each held exactly 10 cycles. Busy drops after the stop bit. Total 100 cycles.
- T3, FIFO fill and back-pressure with Depth=4: hold DataInValid=1 and push 0x01..0x06 on consecutive edges.
  - Bytes 0x01..0x05 are accepted on edges 0..4.
  - Level=4 and DataInReady=0 after edge 4.
  - 0x06 is accepted on the edge after frame 1's pop-on-STOP frees a slot.
  - Six frames go out in order with no idle cycle between frames (600 contiguous cycles).
- T4, reset mid-frame: push 0x0F; assert Reset=0 during bit 3 -> SOut=1 immediately (before the next edge), Level=0. After release the line stays idle, and the queued byte is not sent.
- T5, loopback (default params): connect SOut to the UART receiver SIn and push 0x5A, 0xFF, 0x00 -> the receiver reports DataOutValid three times with DataOut 0x5A, 0xFF, 0x00 in that order.
- T6, simultaneous push/pop: with Level=1 and the transmitter in STOP's last cycle, push 0x33 on the pop edge -> Level stays 1, and frames go out in order (previous head, then 0x33).
